// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
//   state_t      : display FSM states (BLANK until the first value arrives, then SCAN)
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : middle-bar-only pattern shown for non-BCD digits
//   digit_to_seg : 4-bit digit -> active-low {g,f,e,d,c,b,a} pattern
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational digit decoder for one display position.
//   i_digit : BCD digit to show (values above 9 decode to a dash)
//   i_blank : force all segments off (leading-zero suppression)
//   o_seg   : active-low segment pattern {g,f,e,d,c,b,a}
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : digit_to_seg(i_digit);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with a one-deep load buffer.
// A new value is held in a pending register and moved to the display register
// only at a frame boundary, so a frame never shows a mix of old and new digits.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   load   : offer of a new value on bcd_in (taken when load && ready)
//   bcd_in : four BCD digits, [3:0] = ones ... [15:12] = thousands
//   ready  : pending buffer empty
//   seg    : active-low segments {g,f,e,d,c,b,a}, registered
//   an     : active-low one-hot digit enable, registered
//   err    : sticky flag, a non-BCD digit was transferred for display
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV      = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] bcd_in,
  output logic        ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err
);

  localparam int             CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_pend;
  logic          r_full;
  logic [15:0]   r_disp;
  state_t        r_state;
  logic          r_err;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_tick;
  logic          w_frame;
  logic          w_xfer;
  logic          w_accept;
  logic          w_pend_bad;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_seg;
  logic [3:0]    w_an;

  assign w_tick   = (r_cnt == CNT_MAX);
  assign w_frame  = w_tick && (r_idx == 2'd3);
  assign w_xfer   = w_frame && r_full;
  // While full, ready is low, so an accept can never coincide with a transfer;
  // a load taken on a boundary cycle therefore waits for the next boundary.
  assign w_accept = load && !r_full;

  assign w_pend_bad = (r_pend[3:0]   > 4'd9) || (r_pend[7:4]   > 4'd9) ||
                      (r_pend[11:8]  > 4'd9) || (r_pend[15:12] > 4'd9);

  // Digit select and leading-zero detection for the current scan position.
  // A non-BCD digit is non-zero, so it can never satisfy the blanking test.
  always_comb begin
    w_digit = r_disp[4*r_idx +: 4];
    w_blank = 1'b0;
    case (r_idx)
      2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
      2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
      2'd3:    w_blank = (r_disp[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
    w_blank = w_blank && BLANK_LZ;
    w_an    = ~(4'b0001 << r_idx);
  end

  bcd_to_seg u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 16'd0;
      r_full <= 1'b0;
    end else if (w_xfer) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_pend <= bcd_in;
      r_full <= 1'b1;
    end
  end

  // Display FSM with registered outputs: seg/an follow the index and display
  // contents of the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLANK;
      r_disp  <= 16'd0;
      r_err   <= 1'b0;
      r_an    <= 4'b1111;
      r_seg   <= SEG_BLANK;
    end else begin
      case (r_state)
        BLANK: begin
          r_an  <= 4'b1111;
          r_seg <= SEG_BLANK;
          if (w_xfer) r_state <= SCAN;
        end
        SCAN: begin
          r_an  <= w_an;
          r_seg <= w_seg;
        end
        default: r_state <= BLANK;
      endcase
      if (w_xfer) begin
        r_disp <= r_pend;
        if (w_pend_bad) r_err <= 1'b1;
      end
    end
  end

  assign ready = ~r_full;
  assign seg   = r_seg;
  assign an    = r_an;
  assign err   = r_err;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int DIV      = 4;
  localparam bit BLANK_LZ = 1'b1;
  localparam int FRAME    = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'd0;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;

  int checks = 0;
  int failures = 0;

  // Reference model: time is a plain cycle count since reset release.
  int          m_n;
  logic        m_full;
  logic [15:0] m_pend;
  logic [15:0] m_disp;
  logic        m_scan;
  logic        m_err;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;

  seg_scan_driver #(.DIV(DIV), .BLANK_LZ(BLANK_LZ)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .bcd_in (bcd_in),
    .ready  (ready),
    .seg    (seg),
    .an     (an),
    .err    (err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0; m_full = 1'b0; m_pend = 16'd0; m_disp = 16'd0;
    m_scan = 1'b0; m_err = 1'b0; e_an = 4'hF; e_seg = 7'h7F;
  endtask

  task automatic model_update();
    int idx;
    bit frame;
    logic [15:0] upper;
    idx   = (m_n / DIV) % 4;
    frame = ((m_n % DIV) == DIV - 1) && (idx == 3);
    if (!m_scan) begin
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      e_an  = 4'hF & ~(4'd1 << idx);
      upper = m_disp >> (4 * idx);
      if (BLANK_LZ && idx > 0 && upper == 16'd0) e_seg = 7'h7F;
      else e_seg = enc(upper[3:0]);
    end
    if (frame && m_full) begin
      m_disp = m_pend; m_full = 1'b0; m_scan = 1'b1;
      for (int k = 0; k < 4; k++)
        if (((m_pend >> (4 * k)) & 16'hF) > 16'd9) m_err = 1'b1;
    end else if (load && !m_full) begin
      m_pend = bcd_in; m_full = 1'b1;
    end
    m_n++;
  endtask

  // One clock: model advances at the edge, DUT compared at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_update();
    @(negedge clk);
    checks++;
    if (an !== e_an || seg !== e_seg || ready !== !m_full || err !== m_err) begin
      failures++;
      $display("FAIL cycle n=%0d an=%b exp=%b seg=%h exp=%h ready=%b exp=%b err=%b exp=%b",
               m_n, an, e_an, seg, e_seg, ready, !m_full, err, m_err);
    end
  endtask

  task automatic load_val(input logic [15:0] v);
    load = 1'b1; bcd_in = v;
    step();
    load = 1'b0; bcd_in = 16'($urandom);
  endtask

  task automatic wait_ready(input string name, output int k);
    k = 0;
    do begin step(); k++; end while (ready !== 1'b1 && k < 4 * FRAME);
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready timeout got=%b want=1", name, ready);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int k = 0;
    do begin step(); k++; end while (an !== target && k < 4 * FRAME);
    if (an !== target) begin
      failures++;
      $display("FAIL %s an timeout got=%b want=%b", name, an, target);
    end
  endtask

  task automatic chk_seg(input string name, input logic [6:0] want);
    checks++;
    if (seg !== want) begin
      failures++;
      $display("FAIL %s seg got=%h want=%h", name, seg, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_immediate an=%b seg=%h ready=%b err=%b want 1111/7f/1/0",
               an, seg, ready, err);
    end
    model_reset();
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || ready !== 1'b1 || err !== 1'b0) begin
        failures++;
        $display("FAIL idle_blank i=%0d an=%b seg=%h ready=%b err=%b", i, an, seg, ready, err);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] cap_an[16];
    logic [6:0] cap_seg[16];
    logic [3:0] want_an[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] want_seg[4] = '{7'h24, 7'h19, 7'h7F, 7'h7F};
    do_reset();
    load_val(16'h0042);
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL basic_ready got=%b want=0", ready);
    end
    wait_an(4'b1110, "basic_first");
    cap_an[0] = an; cap_seg[0] = seg;
    for (int i = 1; i < 16; i++) begin
      step(); cap_an[i] = an; cap_seg[i] = seg;
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_an[i] !== want_an[i/4] || cap_seg[i] !== want_seg[i/4]) begin
        failures++;
        $display("FAIL basic_scan i=%0d an=%b want=%b seg=%h want=%h",
                 i, cap_an[i], want_an[i/4], cap_seg[i], want_seg[i/4]);
      end
    end
  endtask

  task automatic test_ignore();
    int k;
    wait_ready("ignore_pre", k);
    load_val(16'h1234);
    load = 1'b1; bcd_in = 16'h5678;
    step();
    load = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL ignore_ready got=%b want=0", ready);
    end
    wait_ready("ignore_xfer", k);
    wait_an(4'b1110, "ignore_d0"); chk_seg("ignore_d0", 7'h19);
    wait_an(4'b1101, "ignore_d1"); chk_seg("ignore_d1", 7'h30);
    wait_an(4'b1011, "ignore_d2"); chk_seg("ignore_d2", 7'h24);
    wait_an(4'b0111, "ignore_d3"); chk_seg("ignore_d3", 7'h79);
  endtask

  task automatic test_invalid();
    int k;
    wait_ready("inv_pre", k);
    load_val(16'h00A0);
    wait_ready("inv_xfer", k);
    wait_an(4'b1110, "inv_d0"); chk_seg("inv_d0", 7'h40);
    wait_an(4'b1101, "inv_d1"); chk_seg("inv_d1", 7'h3F);
    wait_an(4'b1011, "inv_d2"); chk_seg("inv_d2", 7'h7F);
    wait_an(4'b0111, "inv_d3"); chk_seg("inv_d3", 7'h7F);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL inv_err got=%b want=1", err); end
    load_val(16'h0001);
    wait_ready("inv_xfer2", k);
    repeat (5) step();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL inv_err_sticky got=%b want=1", err); end
  endtask

  task automatic test_boundary();
    int k = 0;
    wait_ready("bnd_pre", k);
    k = 0;
    while ((m_n % FRAME) != FRAME - 1 && k < 2 * FRAME) begin step(); k++; end
    load_val(16'h0356);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL bnd_ready got=%b want=0", ready); end
    wait_ready("bnd_xfer", k);
    checks++;
    if (k != FRAME) begin
      failures++; $display("FAIL bnd_latency got=%0d want=%0d", k, FRAME);
    end
    wait_an(4'b1110, "bnd_d0"); chk_seg("bnd_d0", 7'h02);
  endtask

  task automatic test_reset_mid();
    int k;
    wait_ready("rm_pre", k);
    load_val(16'h9999);
    wait_ready("rm_xfer", k);
    repeat (6) step();
    #2;
    do_reset();
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      failures++; $display("FAIL rm_blank an=%b seg=%h want 1111/7f", an, seg);
    end
    load_val(16'h0005);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL rm_load_ready got=%b want=0", ready); end
    wait_ready("rm_xfer2", k);
    wait_an(4'b1110, "rm_d0"); chk_seg("rm_d0", 7'h12);
  endtask

  task automatic test_random();
    logic [15:0] v;
    int zeros;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        zeros = $urandom_range(0, 3);
        v = 16'd0;
        for (int d = 0; d < 4; d++) begin
          logic [3:0] dig;
          dig = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
          if (d >= 4 - zeros) dig = 4'd0;
          v = v | (16'(dig) << (4 * d));
        end
        load = ($urandom_range(0, 3) == 0);
        bcd_in = v;
        step();
      end
    end
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_ignore();
    test_invalid();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIV, default 4, clock cycles per digit slot (>=2).
REQ-002 Parameter BLANK_LZ, default 1, enables leading-zero blanking.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 load  input  1  offer of new value on bcd_in.
REQ-007 bcd_in  input  16  four BCD digits; [3:0]=digit0 (ones) ... [15:12]=digit3; digit1 normally fed from bin2bcd carry.
REQ-008 ready  output  1  pending buffer empty; load accepted when load&&ready.
REQ-009 seg  output  7  active-low segments, [6:0]=g,f,e,d,c,b,a.
REQ-010 an  output  4  active-low one-hot digit enable, an[k]=digit k.
REQ-011 err  output  1  sticky: an invalid digit (>9) was displayed.

Function
REQ-012 Prescaler SHALL count 0..DIV-1 and wrap; tick = (count==DIV-1).
REQ-013 Digit index SHALL advance on tick, 0->1->2->3->0; frame boundary = tick while index==3.
REQ-014 Accepted load SHALL write bcd_in to pending register and set pending-full (ready=0 next cycle).
REQ-015 At a frame boundary with pending full, pending SHALL transfer to display register, pending-full clears, ready=1 next cycle.
REQ-016 No bypass: a load accepted on a frame-boundary cycle SHALL be transferred at the following frame boundary, not the current one.
REQ-017 load while ready=0 SHALL be ignored; pending contents unchanged.
REQ-018 FSM states: BLANK (an=4'b1111, seg=7'h7F) after reset; SCAN entered on first transfer; no return to BLANK except reset.
REQ-019 In SCAN, an SHALL drive the current index low only; seg SHALL show that digit.
REQ-020 seg and an SHALL be registered: they reflect the index/display values of the previous cycle (1-cycle latency).
REQ-021 Encodings (hex, active-low): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10, invalid(A-F)=3F (dash), blank=7F.
REQ-022 With BLANK_LZ=1, digit k (k=1..3) SHALL show blank when digits k..3 are all zero; digit0 never blanked.
REQ-023 An invalid digit SHALL never be blanked and SHALL set err on the transfer that loads it; err holds until reset.
REQ-024 an SHALL still be driven active for blanked digits (scan timing constant).

Reset
REQ-025 On rst: prescaler=0, index=0, display=0, pending=0, pending-full=0, state=BLANK.
REQ-026 Outputs during/after reset: ready=1, an=4'b1111, seg=7'h7F, err=0.
REQ-027 Reset mid-frame SHALL discard pending and display values; the first load after release is accepted normally.

Structure
REQ-028 Shared package seg_pkg SHALL hold the state enum (BLANK, SCAN), segment constants (SEG_BLANK, SEG_DASH) and the digit-to-segment function.
REQ-029 One sub-module, bcd_to_seg (4-bit digit + blank flag -> 7-bit active-low pattern), SHALL be instantiated once on the selected digit.
REQ-030 Prescaler, index, pending/display registers and FSM SHALL live in seg_scan_driver.

Verification
REQ-031 Reset, no load, 40 cycles -> an=1111, seg=7F, ready=1, err=0 throughout.
REQ-032 DIV=4, load 16'h0042 -> ready=0; after next frame boundary digit0=24, digit1=19, digits2/3=7F; each an low exactly 4 cycles, order 1110,1101,1011,0111.
REQ-033 Loads 16'h1234 then 16'h5678 while ready=0 -> 5678 ignored; display shows 1,2,3,4 only; ready returns 1 one cycle after transfer.
REQ-034 Load 16'h00A0 -> digit1 shows 3F, digit2/3 blank, digit0 shows 40, err=1 and stays 1 after later load 16'h0001.
REQ-035 Load asserted exactly on frame-boundary cycle -> value appears only after the next boundary (4*DIV cycles later).
REQ-036 Assert rst mid-scan after 16'h9999 displayed -> immediate an=1111, seg=7F, err=0, ready=1; BLANK until next load.
